// File: rtl/insn_prefetch.sv
// Instruction prefetch stage: owns the fetch PC, issues one-cycle-latency word
// reads to instruction memory, buffers returned words in a small FIFO and hands
// them to the decoder over a valid/stall handshake. A redirect flushes buffered
// and in-flight words and restarts fetch at a new address.
module insn_prefetch #(
  parameter int unsigned LEN_INSN      = 32,
  parameter int unsigned MEM_INSN_ADDR = 10,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned RESET_ADDR    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_i,
  input  logic [MEM_INSN_ADDR-1:0] redirect_addr_i,
  output logic                     imem_req_o,
  output logic [MEM_INSN_ADDR-1:0] imem_addr_o,
  input  logic [LEN_INSN-1:0]      imem_data_i,
  output logic                     valid_o,
  input  logic                     stall_i,
  output logic [LEN_INSN-1:0]      insn_o,
  output logic [MEM_INSN_ADDR-1:0] pc_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [MEM_INSN_ADDR-1:0] pc_q, pc_d;
  logic                     inflight_q, inflight_d;
  logic [MEM_INSN_ADDR-1:0] resp_addr_q, resp_addr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [LEN_INSN-1:0]      fifo_insn_q [DEPTH];
  logic [LEN_INSN-1:0]      fifo_insn_d [DEPTH];
  logic [MEM_INSN_ADDR-1:0] fifo_pc_q   [DEPTH];
  logic [MEM_INSN_ADDR-1:0] fifo_pc_d   [DEPTH];

  logic [OCC_W-1:0]         occupancy;
  logic                     issue;
  logic                     push;
  logic                     pop;

  // Handshake and request decode from registered occupancy (pops are not credited)
  always_comb begin
    occupancy = {1'b0, count_q} + OCC_W'(inflight_q);
    issue     = rst & ~redirect_i & (occupancy < OCC_W'(DEPTH));
    push      = inflight_q;
    pop       = valid_o & ~stall_i;
  end

  assign imem_req_o  = issue;
  assign imem_addr_o = pc_q;
  assign valid_o     = (count_q != '0);
  assign insn_o      = fifo_insn_q[rd_ptr_q];
  assign pc_o        = fifo_pc_q[rd_ptr_q];

  // Next-state: fetch PC, in-flight tracking and FIFO push/pop; redirect wins
  always_comb begin
    pc_d        = pc_q;
    inflight_d  = inflight_q;
    resp_addr_d = resp_addr_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_insn_d = fifo_insn_q;
    fifo_pc_d   = fifo_pc_q;

    if (redirect_i) begin
      pc_d       = redirect_addr_i;
      inflight_d = 1'b0;
      count_d    = '0;
      wr_ptr_d   = rd_ptr_q;
    end else begin
      if (issue) begin
        pc_d        = pc_q + MEM_INSN_ADDR'(1);
        inflight_d  = 1'b1;
        resp_addr_d = pc_q;
      end else begin
        inflight_d  = 1'b0;
      end

      if (push) begin
        fifo_insn_d[wr_ptr_q] = imem_data_i;
        fifo_pc_d[wr_ptr_q]   = resp_addr_q;
        wr_ptr_d              = wr_ptr_q + PTR_W'(1);
      end

      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end

      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers; reset also clears FIFO storage so the head reads zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= MEM_INSN_ADDR'(RESET_ADDR);
      inflight_q  <= 1'b0;
      resp_addr_q <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_insn_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      resp_addr_q <= resp_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fifo_insn_q <= fifo_insn_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

endmodule
